cfork2_d_sync: RTL
==================

Name: cfork2_d_sync

Overview:
- Clocked two-way fork with data, for the FPGA control fabric: one 2-phase drive/free channel in, two 2-phase channels out.
- Takes a 2*DATA_WIDTH token, splits it into low and high halves, and fires both outputs together.
- Returns the upstream free only after both downstream frees have arrived.
- Sits between the asynchronous click-style pipeline (toggle signalling) and synchronous logic; synchronises all incoming handshake events.

Parameters:
- DATA_WIDTH, 32, width of each output half; input data is 2*DATA_WIDTH.
- SYNC_STAGES, 2, flip-flop depth of each input handshake synchroniser; legal range 2..4.

Ports:
- clk  input  1  single clock for all state.
- rst  input  1  asynchronous, active-low reset.
- i_drive  input  1  upstream request; every transition (either edge) is one event.
- o_free  output  1  upstream acknowledge; toggles once per completed token.
- i_data  input  2*DATA_WIDTH  token data; stable from before the i_drive transition until the o_free transition.
- o_drive0  output  1  request to branch 0; toggles once per token.
- i_free0  input  1  acknowledge from branch 0; each transition is one event.
- o_data0  output  DATA_WIDTH  registered i_data[DATA_WIDTH-1:0].
- o_drive1  output  1  request to branch 1; toggles once per token.
- i_free1  input  1  acknowledge from branch 1; each transition is one event.
- o_data1  output  DATA_WIDTH  registered i_data[2*DATA_WIDTH-1:DATA_WIDTH].
- o_busy  output  1  high while a token is outstanding, i.e. FSM state is WAIT.
- o_err  output  1  sticky protocol-violation flag.

Behaviour:
- Reset (rst=0, asynchronous): all synchroniser and edge flops 0; o_free, o_drive0, o_drive1, o_busy, o_err = 0; o_data0 = o_data1 = 0; got0 = got1 = 0; state IDLE.
- Reset mid-token discards the token; no free is returned. Both neighbours must be reset too, since the phase reference is 0.
- Synchronisers: each of i_drive, i_free0, i_free1 passes through SYNC_STAGES flops and then one history flop.
- ev_x = last sync stage XOR history flop; it is high for exactly one cycle per input transition.
- FSM states: IDLE, WAIT.
- IDLE, on ev_drive at a clock edge:
  - capture i_data into o_data0/o_data1;
  - toggle o_drive0 and o_drive1 at that same edge, so data and drive update together;
  - clear got0/got1; go to WAIT; o_busy=1.
- Latency: the i_drive transition is sampled at edge E; o_drive0/1 toggle at edge E+SYNC_STAGES.
- WAIT:
  - got0 is set on ev_free0 and got1 on ev_free1.
  - Completion condition: (got0|ev_free0) & (got1|ev_free1). Both frees arriving in the same cycle is legal.
  - On completion: toggle o_free, clear got0/got1, return to IDLE; o_busy=0 from that edge.
  - Free-to-o_free latency: SYNC_STAGES cycles after the sampling edge of the later free.
- o_data0/o_data1 hold their value until the next capture.
- Errors: o_err is set (cleared only by reset) on any of:
  - ev_drive while in WAIT;
  - ev_free0 or ev_free1 while in IDLE;
  - ev_free0 while got0=1, or ev_free1 while got1=1.
- Erroneous events are otherwise ignored: no capture, no toggle, no state change.
- ev_drive in the same cycle as completion is an error; the next token must arrive after the o_free toggle.
- The block has no buffering: throughput is one token per round trip.

Test Plan:
- Reset: hold rst=0 with inputs toggling -> all outputs 0; release -> still 0, state IDLE, o_busy=0.
- Single token, SYNC_STAGES=2: i_data=64'hAAAA_5555_1234_5678, toggle i_drive -> o_data0=32'h1234_5678, o_data1=32'hAAAA_5555, both drives toggle 2 cycles after the sampling edge; toggle i_free0, then i_free1 3 cycles later -> o_free toggles once, 2 cycles after i_free1 is sampled; o_busy falls.
- Simultaneous frees: i_free0 and i_free1 toggle in the same cycle -> single o_free toggle, no o_err.
- Reversed order and back-to-back: 8 tokens with incrementing data, free1 before free0 -> 8 o_free toggles, o_drive0/1 each end at 0, data matches every token.
- Violations:
  - i_drive toggled twice before any free -> o_err=1, outputs unchanged for the second event;
  - after reset, a lone i_free1 toggle -> o_err=1.
- Reset mid-token: drive issued, rst pulsed low before the frees -> outputs return to 0, no o_free toggle; a fresh token then completes normally.

Source files
------------

// File: rtl/cfork2_d_sync.sv
// cfork2_d_sync: clocked two-way fork for 2-phase (toggle) handshakes.
// One drive/free channel in, two drive/free channels out. The incoming
// 2*DATA_WIDTH token is split into a low half (branch 0) and a high half
// (branch 1). Both outputs fire together. The upstream free is returned only
// after both branch frees have arrived. Every incoming handshake line is
// synchronised, and a history flop turns each transition into a one-cycle
// event.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no token outstanding; waiting for an upstream drive event
// WAIT  | token forwarded; collecting free events from both branches
module cfork2_d_sync #(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_drive,
    output logic                    o_free,
    input  logic [2*DATA_WIDTH-1:0] i_data,
    output logic                    o_drive0,
    input  logic                    i_free0,
    output logic [DATA_WIDTH-1:0]   o_data0,
    output logic                    o_drive1,
    input  logic                    i_free1,
    output logic [DATA_WIDTH-1:0]   o_data1,
    output logic                    o_busy,
    output logic                    o_err
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
        $error("cfork2_d_sync: SYNC_STAGES must be in 2..4");
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Bit order in the synchroniser lanes: [0]=drive, [1]=free0, [2]=free1.
    logic [SYNC_STAGES-1:0][2:0] sync_q;
    logic [2:0]                  hist_q;
    logic [2:0]                  ev;
    logic                        ev_drive;
    logic                        ev_free0;
    logic                        ev_free1;

    state_t                  state_q, state_nx;
    logic                    free_q, free_nx;
    logic                    drive_q, drive_nx;
    logic [DATA_WIDTH-1:0]   data0_q, data0_nx;
    logic [DATA_WIDTH-1:0]   data1_q, data1_nx;
    logic                    got0_q, got0_nx;
    logic                    got1_q, got1_nx;
    logic                    err_q, err_nx;
    logic                    done0;
    logic                    done1;

    // Synchroniser chains plus one history flop per line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            hist_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], {i_free1, i_free0, i_drive}};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Any change of a synchronised line is one event, high for a single cycle.
    assign ev       = sync_q[SYNC_STAGES-1] ^ hist_q;
    assign ev_drive = ev[0];
    assign ev_free0 = ev[1];
    assign ev_free1 = ev[2];

    // A branch counts as done if it was seen earlier or is being seen now.
    assign done0 = got0_q | ev_free0;
    assign done1 = got1_q | ev_free1;

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            free_q  <= 1'b0;
            drive_q <= 1'b0;
            data0_q <= '0;
            data1_q <= '0;
            got0_q  <= 1'b0;
            got1_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_nx;
            free_q  <= free_nx;
            drive_q <= drive_nx;
            data0_q <= data0_nx;
            data1_q <= data1_nx;
            got0_q  <= got0_nx;
            got1_q  <= got1_nx;
            err_q   <= err_nx;
        end
    end

    // Next-state logic. Events that violate the protocol only raise the
    // sticky error; they never capture data, toggle a line or move the FSM.
    always_comb begin
        state_nx = state_q;
        free_nx  = free_q;
        drive_nx = drive_q;
        data0_nx = data0_q;
        data1_nx = data1_q;
        got0_nx  = got0_q;
        got1_nx  = got1_q;
        err_nx   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (ev_free0 || ev_free1) begin
                    err_nx = 1'b1;
                end
                if (ev_drive) begin
                    data0_nx = i_data[DATA_WIDTH-1:0];
                    data1_nx = i_data[2*DATA_WIDTH-1:DATA_WIDTH];
                    drive_nx = ~drive_q;
                    got0_nx  = 1'b0;
                    got1_nx  = 1'b0;
                    state_nx = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (ev_drive || (ev_free0 && got0_q) || (ev_free1 && got1_q)) begin
                    err_nx = 1'b1;
                end
                if (done0 && done1) begin
                    free_nx  = ~free_q;
                    got0_nx  = 1'b0;
                    got1_nx  = 1'b0;
                    state_nx = ST_IDLE;
                end else begin
                    got0_nx = done0;
                    got1_nx = done1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    assign o_free   = free_q;
    assign o_drive0 = drive_q;
    assign o_drive1 = drive_q;
    assign o_data0  = data0_q;
    assign o_data1  = data1_q;
    assign o_busy   = (state_q == ST_WAIT);
    assign o_err    = err_q;

endmodule
